// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned 16x16 shift-add multiplier around a 16-bit carry-lookahead adder.
// word_CLA is the two-level (4-bit group) lookahead adder the multiplier drives each cycle.
module word_CLA (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        CIn,
    output logic [15:0] Sum,
    output logic        COut,
    output logic        Overflow
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, pg;
    logic [4:0]  gc;
    assign g = A & B;
    assign p = A ^ B;
    genvar k;
    for (k = 0; k < 4; k++) begin : grp
        assign gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+3:4*k+2] & g[4*k+1])
                     | (&p[4*k+3:4*k+1] & g[4*k]);
        assign pg[k] = &p[4*k+3:4*k];
        assign c[4*k]   = gc[k];
        assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
        assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k+1:4*k] & gc[k]);
        assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+2:4*k+1] & g[4*k])
                        | (&p[4*k+2:4*k] & gc[k]);
    end
    // Second lookahead level: group carries straight from group generate/propagate.
    assign gc[0] = CIn;
    assign gc[1] = gg[0] | (pg[0] & CIn);
    assign gc[2] = gg[1] | (pg[1] & gg[0]) | (&pg[1:0] & CIn);
    assign gc[3] = gg[2] | (pg[2] & gg[1]) | (&pg[2:1] & gg[0]) | (&pg[2:0] & CIn);
    assign gc[4] = gg[3] | (pg[3] & gg[2]) | (&pg[3:2] & gg[1]) | (&pg[3:1] & gg[0])
                 | (&pg[3:0] & CIn);
    assign Sum      = p ^ c;
    assign COut     = gc[4];
    assign Overflow = gc[4] ^ c[15];
endmodule

module shift_add_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        ovfl
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [15:0] m, acc, q, sum;
    logic [4:0]  cnt;
    logic        cout, unused_ovf;
    logic [31:0] nxt;
    word_CLA u_cla (
        .A(acc),
        .B(q[0] ? m : 16'h0000),
        .CIn(1'b0),
        .Sum(sum),
        .COut(cout),
        .Overflow(unused_ovf)
    );
    // Carry-out lands in ACC[15] so no bit of the partial product is lost.
    assign nxt = {cout, sum, q[15:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            ovfl    <= 1'b0;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m     <= A;
                    q     <= B;
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    {acc, q} <= nxt;
                    cnt      <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        product <= nxt;
                        ovfl    <= |nxt[31:16];
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: randomized and directed checks of shift_add_mult against plain A*B arithmetic.
module tb_shift_add_mult;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, ovfl;
    logic [31:0] product;
    int          checks = 0, errors = 0;

    shift_add_mult dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .product(product), .ovfl(ovfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where busy has dropped.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input string tag);
        logic [31:0] exp, got_p;
        logic        got_o;
        int          nbusy, ndone;
        exp   = 32'(x) * 32'(y);
        nbusy = 0;
        ndone = 0;
        got_p = '0;
        got_o = 1'b0;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int t = 0; t < 60 && busy; t++) begin
            nbusy++;
            if (done) begin
                ndone++;
                got_p = product;
                got_o = ovfl;
            end
            @(negedge clk);
        end
        chk({tag, " product"}, got_p, exp);
        chk({tag, " ovfl"}, 32'(got_o), 32'(exp > 32'hFFFF));
        chk({tag, " busy cycles"}, nbusy, 17);
        chk({tag, " done count"}, ndone, 1);
        chk({tag, " product held"}, product, exp);
    endtask

    initial begin
        int nd;
        #2;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset product", product, 0);
        chk("reset ovfl", 32'(ovfl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'd3, 16'd5, "3x5");
        run_op(16'hFFFF, 16'hFFFF, "ffff");
        run_op(16'h00FF, 16'h0101, "00ff");
        run_op(16'h0100, 16'h0100, "0100");
        run_op(16'h0000, 16'hFFFF, "zero");

        // Starts while busy must be ignored, including during DONE.
        a = 16'd7;
        b = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int t = 0; t < 30; t++) begin
            if (done) nd++;
            start = (t == 4) || done;
            a = start ? 16'd2 : 16'd7;
            b = start ? 16'd2 : 16'd9;
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy start done count", nd, 1);
        chk("busy start product", product, 32'h3F);
        chk("busy start idle", 32'(busy), 0);
        run_op(16'd2, 16'd2, "2x2");

        // Reset mid-operation aborts without a done.
        run_op(16'd6, 16'd7, "6x7");
        a = 16'h1234;
        b = 16'h5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort product", product, 0);
        chk("abort ovfl", 32'(ovfl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int t = 0; t < 25; t++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("abort no activity", nd, 0);
        run_op(16'd2, 16'd3, "2x3");

        for (int i = 0; i < 100; i++)
            run_op(16'($urandom), 16'($urandom), $sformatf("rnd%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
